uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter BITS_PER_WORD, 8, data bits per UART word.
REQ-002 Parameter W_OUT, 16, input bus width; SHALL be a multiple of BITS_PER_WORD; NUM_WORDS = W_OUT/BITS_PER_WORD.
REQ-003 Parameter DIV_W, 16, width of the runtime clocks-per-bit divisor.
REQ-004 Parameter PAD_BITS, 0, extra idle-high bits appended after the stop bits of every word.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 cfg_div  input  DIV_W  clocks per UART bit; values 0 and 1 are treated as 2.
REQ-008 cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-009 cfg_stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 s_valid  input  1  input data valid.
REQ-011 s_ready  output  1  block can accept a frame.
REQ-012 s_data  input  W_OUT  frame payload; word 0 = s_data[BITS_PER_WORD-1:0].
REQ-013 tx  output  1  serial line, idle high.
REQ-014 busy  output  1  high from accept until the last bit period of the last word ends.

Function
REQ-015 Transfer SHALL occur only on a rising edge where s_valid && s_ready; s_data, cfg_div, cfg_parity and cfg_stop2 SHALL be latched at that edge.
REQ-016 Config inputs changing after accept SHALL NOT affect the frame in progress.
REQ-017 s_ready SHALL deassert on the cycle after accept and stay low until the frame ends.
REQ-018 tx SHALL drive the start bit (0) beginning the cycle after accept.
REQ-019 Each bit SHALL last exactly the latched divisor (min 2) cycles.
REQ-020 Per word, bit order: start (0), data LSB first, parity (if enabled), stop bits (1), PAD_BITS idle bits (1).
REQ-021 Words SHALL be sent word 0 to word NUM_WORDS-1 with no gap between the last bit of one word and the start bit of the next.
REQ-022 Even parity bit = XOR of data bits; odd parity bit = its inverse.
REQ-023 FSM states: IDLE, START, DATA, PARITY, STOP, PAD; IDLE->START on accept; START->DATA; DATA->PARITY when parity active, else STOP; PARITY->STOP; STOP->PAD if PAD_BITS>0, else next-word START or IDLE; PAD->next-word START or IDLE.
REQ-024 After the last bit period, the FSM SHALL enter IDLE with s_ready=1 and tx=1; this guarantees at least one idle-high cycle between frames.
REQ-025 s_valid asserted while s_ready=0 SHALL be ignored; data is not queued.
REQ-026 busy SHALL equal !s_ready outside reset.

Reset
REQ-027 While rst is high at a clock edge: tx=1, s_ready=0, busy=0, FSM=IDLE, all counters 0.
REQ-028 s_ready SHALL rise on the first edge where rst is low.
REQ-029 Reset mid-frame SHALL abort the frame; no partial word is resumed.

Configuration
REQ-030 Macro UART_TX_PARITY_EN: when defined, parity is generated per cfg_parity.
REQ-031 When UART_TX_PARITY_EN is undefined, cfg_parity SHALL be ignored, no parity bit is ever sent, and the port SHALL remain present.

Verification (BITS_PER_WORD=8, W_OUT=16, PAD_BITS=0, cfg_div=4)
REQ-032 s_data=16'hA53C, parity none, stop1 -> tx sends 0x3C then 0xA5, 10 bits x 4 cycles each; s_ready returns after 80 cycles.
REQ-033 UART_TX_PARITY_EN defined, s_data=16'h013C, even -> parity bits 0 then 1; odd -> 1 then 0; frame length 88 cycles.
REQ-034 cfg_div=1, stop2 -> every bit lasts 2 cycles; each word is 11 bits; frame length 44 cycles.
REQ-035 cfg_div changed 4->8 mid-frame -> every bit in the frame stays 4 cycles; the next frame uses 8.
REQ-036 rst pulsed during word 0 data bit 3 -> tx=1 and s_ready=0 while rst is high; s_ready=1 on the first edge after release; no further frame bits are sent.
REQ-037 s_valid held high continuously -> frames are accepted back-to-back with exactly one idle-high cycle between them; no acceptance occurs while busy.

Source files
------------

// File: rtl/uart_tx_framer.sv
// UART transmitter that serialises one W_OUT-bit frame as NUM_WORDS back-to-back words, word 0 first.
// Optional macro UART_TX_PARITY_EN enables the parity bit selected by cfg_parity.
module uart_tx_framer #(
    parameter int BITS_PER_WORD = 8,
    parameter int W_OUT         = 16,
    parameter int DIV_W         = 16,
    parameter int PAD_BITS      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W_OUT-1:0] s_data,
    output logic             tx,
    output logic             busy
);
    localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int CNT_MAX   = (BITS_PER_WORD > PAD_BITS) ? BITS_PER_WORD : PAD_BITS;
    localparam int CNT_W     = $clog2(CNT_MAX + 2);
    localparam int WORD_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PAD} state_t;

    state_t             state_q, state_d;
    logic [W_OUT-1:0]   shift_q, shift_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]  word_cnt_q, word_cnt_d;
    logic               stop2_q, stop2_d;
    logic               par_acc_q, par_acc_d;
    logic               tx_q, tx_d;
    logic               s_ready_q, s_ready_d;
    logic               busy_q, busy_d;
    logic               bit_end;
    logic               word_done;
    logic               par_active;
    logic               par_odd;

`ifdef UART_TX_PARITY_EN
    logic [1:0] parity_q, parity_d;
    assign par_active = (parity_q == 2'b01) || (parity_q == 2'b10);
    assign par_odd    = (parity_q == 2'b10);
`else
    // Port stays present but parity is never generated in this build.
    logic unused_cfg_parity;
    assign unused_cfg_parity = ^cfg_parity;
    assign par_active = 1'b0;
    assign par_odd    = 1'b0;
`endif

    assign bit_end = (div_cnt_q == div_q - DIV_W'(1));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        stop2_d    = stop2_q;
        par_acc_d  = par_acc_q;
        tx_d       = tx_q;
        s_ready_d  = s_ready_q;
        busy_d     = busy_q;
        word_done  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        if (state_q == IDLE) begin
            s_ready_d = 1'b1;
            busy_d    = 1'b0;
            tx_d      = 1'b1;
            div_cnt_d = '0;
            if (s_valid && s_ready_q) begin
                shift_d    = s_data;
                div_d      = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
                stop2_d    = cfg_stop2;
`ifdef UART_TX_PARITY_EN
                parity_d   = cfg_parity;
`endif
                word_cnt_d = '0;
                bit_cnt_d  = '0;
                state_d    = START;
                s_ready_d  = 1'b0;
                busy_d     = 1'b1;
                tx_d       = 1'b0;
            end
        end else if (!bit_end) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end else begin
            div_cnt_d = '0;
            case (state_q)
                START: begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    par_acc_d = 1'b0;
                    tx_d      = shift_q[0];
                end
                DATA: begin
                    // Parity accumulates as bits leave so the last data bit can hand over directly.
                    par_acc_d = par_acc_q ^ shift_q[0];
                    shift_d   = shift_q >> 1;
                    if (bit_cnt_q == CNT_W'(BITS_PER_WORD - 1)) begin
                        bit_cnt_d = '0;
                        if (par_active) begin
                            state_d = PARITY;
                            tx_d    = par_acc_d ^ par_odd;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        tx_d      = shift_d[0];
                    end
                end
                PARITY: begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                end
                STOP: begin
                    if (stop2_q && bit_cnt_q == '0) begin
                        bit_cnt_d = CNT_W'(1);
                    end else if (PAD_BITS > 0) begin
                        state_d   = PAD;
                        bit_cnt_d = '0;
                    end else begin
                        word_done = 1'b1;
                    end
                end
                PAD: begin
                    if (int'(bit_cnt_q) == PAD_BITS - 1) begin
                        word_done = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (word_done) begin
                bit_cnt_d = '0;
                if (word_cnt_q == WORD_W'(NUM_WORDS - 1)) begin
                    state_d   = IDLE;
                    tx_d      = 1'b1;
                    s_ready_d = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    word_cnt_d = word_cnt_q + WORD_W'(1);
                    state_d    = START;
                    tx_d       = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            div_q      <= DIV_W'(2);
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            stop2_q    <= 1'b0;
            par_acc_q  <= 1'b0;
            tx_q       <= 1'b1;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 2'b00;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            stop2_q    <= stop2_d;
            par_acc_q  <= par_acc_d;
            tx_q       <= tx_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign s_ready = s_ready_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: accepted frames are modelled as bit lists, a monitor checks tx per bit period.
module tb_uart_tx_framer;
    localparam int BPW       = 8;
    localparam int W_OUT     = 16;
    localparam int DIV_W     = 16;
    localparam int PAD_BITS  = 0;
    localparam int NUM_WORDS = W_OUT / BPW;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DIV_W-1:0] cfg_div;
    logic [1:0]       cfg_parity;
    logic             cfg_stop2;
    logic             s_valid;
    logic             s_ready;
    logic [W_OUT-1:0] s_data;
    logic             tx;
    logic             busy;

    uart_tx_framer #(
        .BITS_PER_WORD(BPW),
        .W_OUT(W_OUT),
        .DIV_W(DIV_W),
        .PAD_BITS(PAD_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_div(cfg_div),
        .cfg_parity(cfg_parity),
        .cfg_stop2(cfg_stop2),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .tx(tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] bits;
        int           nbits;
        int           div;
    } frame_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     passes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: the UART line as a flat list of bit levels, one entry per bit period.
    function automatic frame_t model(input logic [W_OUT-1:0] d, input logic [DIV_W-1:0] div,
                                     input logic [1:0] par, input logic st2);
        frame_t         f;
        logic [BPW-1:0] w;
        int             n;
        n = 0;
        f.bits = '0;
        f.div = (div < 2) ? 2 : int'(div);
        for (int k = 0; k < NUM_WORDS; k++) begin
            w = d[k*BPW +: BPW];
            f.bits[n] = 1'b0; n++;
            for (int b = 0; b < BPW; b++) begin
                f.bits[n] = w[b]; n++;
            end
            if (PAR_EN && (par == 2'b01 || par == 2'b10)) begin
                f.bits[n] = (^w) ^ (par == 2'b10); n++;
            end
            for (int s = 0; s < (st2 ? 2 : 1) + PAD_BITS; s++) begin
                f.bits[n] = 1'b1; n++;
            end
        end
        f.nbits = n;
        return f;
    endfunction

    // Accept sniffer: pushes the expected frame at every transfer edge.
    int accept_cnt    = 0;
    int edge_no       = 0;
    int last_acc_edge = 0;
    int last_total    = 0;
    bit valid_run     = 1'b0;
    bit edge_rst      = 1'b1;
    bit prev_edge_rst = 1'b1;

    always @(posedge clk) begin : sniff
        frame_t f;
        prev_edge_rst = edge_rst;
        edge_rst = rst;
        edge_no++;
        if (rst) begin
            valid_run = 1'b0;
        end else if (s_valid && s_ready) begin
            f = model(s_data, cfg_div, cfg_parity, cfg_stop2);
            if (valid_run) check("b2b_gap", edge_no - last_acc_edge, last_total + 1);
            exp_q.push_back(f);
            accept_cnt++;
            last_acc_edge = edge_no;
            last_total = f.nbits * f.div;
            valid_run = 1'b1;
        end else if (!s_valid) begin
            valid_run = 1'b0;
        end
    end

    // Monitor: compares the line against the popped frame on the falling edge.
    bit     active = 1'b0;
    frame_t cur;
    int     cyc = 0;
    int     bad = 0;

    always @(negedge clk) begin : mon
        int   bi;
        logic eb;
        if (edge_rst) begin
            active = 1'b0;
            check("rst_tx", int'(tx), 1);
            check("rst_ready", int'(s_ready), 0);
            check("rst_busy", int'(busy), 0);
        end else begin
            if (prev_edge_rst) check("ready_after_rst", int'(s_ready), 1);
            check("busy_vs_ready", int'(busy), int'(!s_ready));
            if (!active && busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", int'(busy), 0);
                end else begin
                    cur = exp_q.pop_front();
                    active = 1'b1;
                    cyc = 0;
                    bad = 0;
                end
            end
            if (active) begin
                if (cyc < cur.nbits * cur.div) begin
                    bi = cyc / cur.div;
                    eb = cur.bits[bi];
                    if (tx !== eb || s_ready !== 1'b0) bad++;
                    if (cyc % cur.div == cur.div - 1) begin
                        check($sformatf("tx_bit%0d_bad_cycles", bi), bad, 0);
                        bad = 0;
                    end
                end else begin
                    check("frame_end_ready", int'(s_ready), 1);
                    check("frame_end_tx", int'(tx), 1);
                    active = 1'b0;
                end
                cyc++;
            end else if (!busy) begin
                check("idle_tx", int'(tx), 1);
            end
        end
    end

    task automatic rand_inputs();
        s_data     = W_OUT'($urandom);
        cfg_div    = DIV_W'($urandom_range(0, 6));
        cfg_parity = 2'($urandom_range(0, 3));
        cfg_stop2  = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [W_OUT-1:0] d, input logic [DIV_W-1:0] div,
                        input logic [1:0] par, input logic st2);
        int c;
        c = accept_cnt;
        s_data = d; cfg_div = div; cfg_parity = par; cfg_stop2 = st2;
        s_valid = 1'b1;
        for (int i = 0; i < 400 && accept_cnt == c; i++) begin
            @(posedge clk); #1;
        end
        check("accept", accept_cnt - c, 1);
        s_valid = 1'b0;
    endtask

    task automatic wait_len(output int len);
        len = 0;
        while (!s_ready && len < 5000) begin
            @(posedge clk); #1;
            len++;
        end
    endtask

    task automatic stream(input int n);
        int c;
        rand_inputs();
        s_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            c = accept_cnt;
            for (int i = 0; i < 400 && accept_cnt == c; i++) begin
                @(posedge clk); #1;
            end
            check("stream_accept", accept_cnt - c, 1);
            rand_inputs();
        end
        s_valid = 1'b0;
    endtask

    initial begin : stim
        int len;
        int w;
        s_valid = 1'b0; s_data = '0; cfg_div = DIV_W'(4); cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        send(16'hA53C, 16'd4, 2'b00, 1'b0);
        wait_len(len); check("len_a53c", len, 80);
        send(16'h013C, 16'd4, 2'b01, 1'b0);
        wait_len(len); check("len_even", len, PAR_EN ? 88 : 80);
        send(16'h013C, 16'd4, 2'b10, 1'b0);
        wait_len(len); check("len_odd", len, PAR_EN ? 88 : 80);
        send(16'h5A0F, 16'd1, 2'b00, 1'b1);
        wait_len(len); check("len_div1_stop2", len, 44);
        send(16'hC3E1, 16'd0, 2'b11, 1'b0);
        wait_len(len); check("len_div0", len, 40);

        // Config changes after accept must not disturb the frame in flight.
        send(16'h1234, 16'd4, 2'b00, 1'b0);
        cfg_div = 16'd8; cfg_stop2 = 1'b1; cfg_parity = 2'b01;
        wait_len(len); check("len_cfg_change", len, 80);
        send(16'h1234, 16'd8, 2'b00, 1'b0);
        wait_len(len); check("len_div8", len, 160);

        // Reset during word 0 data bit 3.
        send(16'hA53C, 16'd4, 2'b00, 1'b0);
        repeat (16) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;

        for (int k = 0; k < 15; k++) begin
            rand_inputs();
            send(s_data, cfg_div, cfg_parity, cfg_stop2);
            wait_len(len);
            w = $urandom_range(0, 3);
            repeat (w) @(posedge clk);
            #1;
        end

        stream(5);
        wait_len(len);
        for (int i = 0; i < 2000 && (exp_q.size() != 0 || active); i++) @(posedge clk);
        check("drained", exp_q.size() + int'(active), 0);
        repeat (5) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
